// File: rtl/sram_like_pkg.sv
// Shared SRAM-like bus definitions: transfer size encoding and byte-lane write-enable decode.
// Used by both the responder and initiator-side logic.
package sram_like_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   // Wide enough to hold an outstanding count of up to 4.
   localparam int unsigned CntW = 3;

   // Size code 3 falls through to a full-word enable.
   function automatic logic [3:0] wen_from_size(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] wen;
      case (size)
         SZ_BYTE: wen = 4'b0001 << off;
         SZ_HALF: wen = 4'b0011 << {off[1], 1'b0};
         default: wen = 4'b1111;
      endcase
      return wen;
   endfunction

endpackage

// File: rtl/sram_like_resp_pipe.sv
// LAT-stage response pipeline: shifts valid/wr per accepted request and carries the read data
// captured from the SRAM one cycle after acceptance out to the data_ok cycle.
module sram_like_resp_pipe #(
   parameter int unsigned LAT = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        push_i,
   input  logic        push_wr_i,
   input  logic [31:0] ram_rdata_i,
   output logic        pop_o,
   output logic [31:0] rdata_o
);

   logic [LAT-1:0] valid_q, valid_d;
   logic [LAT-1:0] wr_q, wr_d;
   logic [31:0]    stage_data [LAT];

   always_comb begin
      valid_d    = '0;
      wr_d       = '0;
      valid_d[0] = push_i;
      wr_d[0]    = push_wr_i;
      for (int i = 1; i < LAT; i++) begin
         valid_d[i] = valid_q[i-1];
         wr_d[i]    = wr_q[i-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         wr_q    <= '0;
      end else begin
         valid_q <= valid_d;
         wr_q    <= wr_d;
      end
   end

   // Stage 0 data is the SRAM output itself; later stages are registered copies.
   assign stage_data[0] = ram_rdata_i;

   if (LAT > 1) begin : g_data
      logic [31:0] data_q [LAT-1];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < LAT - 1; i++) data_q[i] <= '0;
         end else begin
            for (int i = 0; i < LAT - 1; i++) data_q[i] <= stage_data[i];
         end
      end

      for (genvar i = 1; i < LAT; i++) begin : g_stage
         assign stage_data[i] = data_q[i-1];
      end
   end

   assign pop_o   = valid_q[LAT-1];
   assign rdata_o = (pop_o && !wr_q[LAT-1]) ? stage_data[LAT-1] : 32'h0;

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like slave: address handshake, synchronous SRAM drive and a data_ok return LAT cycles
// after each accept. Define SRAM_LIKE_STALL_EN to add LFSR-driven random addr_ok stalls.
module sram_like_responder
   import sram_like_pkg::*;
#(
   parameter int unsigned LAT       = 1,
   parameter int unsigned DEPTH     = 2,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        ram_en,
   output logic [3:0]  ram_wen,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   logic [CntW-1:0] count_q, count_d;
   logic            stall;
   logic            accept;

`ifdef SRAM_LIKE_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Taps 16,14,13,11: maximal-length Fibonacci sequence.
   assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) lfsr_q <= LFSR_SEED;
      else         lfsr_q <= lfsr_d;
   end

   assign stall = (lfsr_q[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   // Registered count only, so addr_ok never sees req or a same-cycle retire.
   assign addr_ok   = resetn && !stall && (count_q < CntW'(DEPTH));
   assign accept    = req && addr_ok;
   assign ram_en    = accept;
   assign ram_wen   = (accept && wr) ? wen_from_size(size, addr[1:0]) : 4'b0000;
   assign ram_addr  = {addr[31:2], 2'b00};
   assign ram_wdata = wdata;

   always_comb begin
      count_d = count_q;
      if (accept && !data_ok)      count_d = count_q + CntW'(1);
      else if (!accept && data_ok) count_d = count_q - CntW'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) count_q <= '0;
      else         count_q <= count_d;
   end

   sram_like_resp_pipe #(
      .LAT (LAT)
   ) u_pipe (
      .clk_i       (clk),
      .rst_ni      (resetn),
      .push_i      (accept),
      .push_wr_i   (wr),
      .ram_rdata_i (ram_rdata),
      .pop_o       (data_ok),
      .rdata_o     (rdata)
   );

endmodule

// File: tb/tb_sram_like_responder.sv
// Randomised bench for sram_like_responder over four LAT/DEPTH configurations, each checked
// cycle by cycle against a transaction-level model (byte memory plus an in-flight queue).
`timescale 1ns/1ps
module tb_sram_like_responder;

   typedef struct {
      int          due;
      logic        wr;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input int inst, input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL [cfg %0d] %s at cycle %0d: got 0x%08h, want 0x%08h",
                  inst, tag, cyc, got, exp);
      end
   endtask

   function automatic logic [7:0] init_byte(input int a);
      return 8'(a * 37 + 11);
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_cfg
      localparam int unsigned L = (g == 1) ? 3 : (g == 3) ? 2 : 1;
      localparam int unsigned D = (g == 2) ? 1 : (g == 3) ? 4 : 2;

      logic        resetn, req, wr;
      logic [1:0]  size;
      logic [31:0] addr, wdata;
      logic        addr_ok, data_ok, ram_en;
      logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;
      logic [3:0]  ram_wen;
      logic        fin = 1'b0;
      int          stuck = 0;
      logic [31:0] mem [128];
      logic [7:0]  ref_mem [int];
      exp_t        q [$];
      logic        stall;

      sram_like_responder #(
         .LAT   (L),
         .DEPTH (D)
      ) u_dut (
         .clk       (clk),
         .resetn    (resetn),
         .req       (req),
         .wr        (wr),
         .size      (size),
         .addr      (addr),
         .wdata     (wdata),
         .addr_ok   (addr_ok),
         .data_ok   (data_ok),
         .rdata     (rdata),
         .ram_en    (ram_en),
         .ram_wen   (ram_wen),
         .ram_addr  (ram_addr),
         .ram_wdata (ram_wdata),
         .ram_rdata (ram_rdata)
      );

`ifdef SRAM_LIKE_STALL_EN
      logic [15:0] lfsr;
      always @(posedge clk) lfsr <= resetn ? lfsr_step(lfsr) : 16'hACE1;
      assign stall = (lfsr % 4) == 0;
`else
      assign stall = 1'b0;
`endif

      // Synchronous SRAM: one-cycle read latency, byte-lane writes.
      initial begin
         logic [31:0] w;
         for (int i = 0; i < 128; i++)
            for (int b = 0; b < 4; b++) mem[i][8*b +: 8] = init_byte(4 * i + b);
         ram_rdata = '0;
         forever begin
            @(posedge clk);
            if (ram_en) begin
               w = mem[ram_addr[8:2]];
               ram_rdata <= w;
               for (int b = 0; b < 4; b++) if (ram_wen[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
               mem[ram_addr[8:2]] <= w;
            end
         end
      end

      function automatic logic [7:0] ref_rd(input int a);
         return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
      endfunction

      always @(negedge clk) begin
         int          n, base;
         logic        exp_ok;
         logic [3:0]  ewen;
         logic [31:0] word;
         if (!resetn) begin
            q.delete();
            check_eq(g, "rst_addr_ok", 32'(addr_ok), 32'h0);
            check_eq(g, "rst_data_ok", 32'(data_ok), 32'h0);
            check_eq(g, "rst_ram_en", 32'(ram_en), 32'h0);
            check_eq(g, "rst_ram_wen", 32'(ram_wen), 32'h0);
            check_eq(g, "rst_rdata", rdata, 32'h0);
         end else begin
            while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
            // Outstanding = everything not yet past its data_ok cycle, including this one.
            exp_ok = (q.size() < int'(D)) && !stall;
            check_eq(g, "addr_ok", 32'(addr_ok), 32'(exp_ok));
            if (q.size() > 0 && q[0].due == cyc) begin
               check_eq(g, "data_ok", 32'(data_ok), 32'h1);
               check_eq(g, "rdata", rdata, q[0].wr ? 32'h0 : q[0].data);
            end else begin
               check_eq(g, "data_ok", 32'(data_ok), 32'h0);
            end
            check_eq(g, "ram_en", 32'(ram_en), 32'(req && exp_ok));
            if (req && exp_ok) begin
               n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
               base = int'(addr) & ~(n - 1);
               ewen = '0;
               word = '0;
               if (wr) begin
                  for (int k = 0; k < n; k++) begin
                     ewen[(base + k) % 4] = 1'b1;
                     ref_mem[base + k] = wdata[8 * ((base + k) % 4) +: 8];
                  end
               end
               for (int k = 0; k < 4; k++) word[8*k +: 8] = ref_rd((base & ~3) + k);
               check_eq(g, "ram_wen", 32'(ram_wen), 32'(ewen));
               check_eq(g, "ram_addr", ram_addr, 32'(base & ~3));
               check_eq(g, "ram_wdata", ram_wdata, wdata);
               q.push_back('{due: cyc + int'(L), wr: wr, data: word});
            end
         end
      end

      task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d);
         int waited;
         waited = 0;
         req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
         @(negedge clk);
         while (!addr_ok && waited < 64) begin
            @(negedge clk);
            waited++;
         end
         if (!addr_ok) stuck++;
         @(posedge clk);
         #1;
         req = 1'b0;
      endtask

      initial begin
         int r;
         resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wdata = '0;
         repeat (3) @(posedge clk);
         #1 resetn = 1'b1;
         case (g)
            0: begin
               issue(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
               issue(1'b0, 2'd2, 32'h100, 32'h0);
               issue(1'b1, 2'd0, 32'h103, 32'hAA000000);
               issue(1'b1, 2'd1, 32'h102, 32'hBBCC0000);
               issue(1'b0, 2'd2, 32'h100, 32'h0);
            end
            1, 2: begin
               issue(1'b0, 2'd2, 32'h0, 32'h0);
               issue(1'b0, 2'd2, 32'h4, 32'h0);
               issue(1'b0, 2'd2, 32'h8, 32'h0);
            end
            default: begin
               issue(1'b0, 2'd2, 32'h10, 32'h0);
               issue(1'b0, 2'd2, 32'h14, 32'h0);
               resetn = 1'b0;
               repeat (2) @(posedge clk);
               #1 resetn = 1'b1;
            end
         endcase
         for (int i = 0; i < 1000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
               resetn = 1'b0;
               @(posedge clk);
               #1 resetn = 1'b1;
            end else if (r < 25) begin
               @(posedge clk);
               #1;
            end else begin
               issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     32'($urandom_range(0, 511)), $urandom);
            end
         end
         repeat (L + 4) @(posedge clk);
         fin = 1'b1;
      end
   end

   initial begin
      int waited = 0;
      while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) && waited < 50000)
      begin
         @(posedge clk);
         waited++;
      end
      check_eq(-1, "all_done",
               {28'd0, g_cfg[3].fin, g_cfg[2].fin, g_cfg[1].fin, g_cfg[0].fin}, 32'hF);
      check_eq(-1, "accept_waits",
               32'(g_cfg[0].stuck + g_cfg[1].stuck + g_cfg[2].stuck + g_cfg[3].stuck), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
